audio_stream_out: RTL and testbench



---
 rtl/audio_out_pkg.sv | 33 +++
 rtl/audio_stream_out_fifo.sv | 60 ++++++
 rtl/audio_stream_out.sv | 211 +++++++++++++++++++++
 tb/tb_audio_stream_out.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_out_pkg
// Description : Register map, bit positions and enums for audio_stream_out.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_out_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int STAT_FULL_BIT     = 16;
  localparam int STAT_EMPTY_BIT    = 17;
  localparam int STAT_UNDERRUN_BIT = 24;
  localparam int STAT_OVERFLOW_BIT = 25;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FRAME_START = 2'd1,
    SHIFT       = 2'd2
  } seq_state_t;

  typedef enum logic {
    I2S = 1'b0,
    TDM = 1'b1
  } audio_mode_t;

endpackage
`default_nettype wire

// File: rtl/audio_stream_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with level; push while full is accepted
//               only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/audio_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : audio_stream_out
// Description : Avalon-MM sample FIFO feeding an I2S/TDM serialiser for WM8731.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_stream_out #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 256,
  parameter int BCLK_DIV = 4,
  parameter int MODE     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        source_ready,
  output logic        irq,
  output logic        aud_bclk,
  output logic        aud_lrck,
  output logic        aud_dacdat
);
  import audio_out_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int SW = $clog2(SLOT_W);
  localparam int CW = $clog2(CHANNELS);
  localparam audio_mode_t C_MODE = (MODE == 1) ? TDM : I2S;

  seq_state_t         r_state, w_state_nx;
  logic               r_en, r_irq_en, r_underrun, r_overflow, r_commit;
  logic [15:0]        r_thresh;
  logic [31:0]        r_readdata, w_status;
  logic [DW-1:0]      r_div_cnt;
  logic               r_bclk, r_lrck, r_dacdat;
  logic [CW-1:0]      r_slot;
  logic [SW-1:0]      r_slot_bit;
  logic [SLOT_W-1:0]  r_shift, w_load_word;
  logic               w_push_req, w_pop, w_fifo_full, w_fifo_empty;
  logic [AW:0]        w_fifo_level;
  logic [SAMPLE_W-1:0] w_fifo_dout;
  logic               w_bclk_fall, w_last_bit, w_slot_end, w_level_ok;
  logic               w_fs_commit, w_fs_starve, w_ovf_evt, w_reg_wr, w_unused;

  assign w_reg_wr    = chipselect & write;
  assign w_push_req  = w_reg_wr & (address == ADDR_DATA);
  assign w_load_word = SLOT_W'(w_fifo_dout) << (SLOT_W - SAMPLE_W);
  assign w_level_ok  = (w_fifo_level >= (AW+1)'(CHANNELS));
  assign w_bclk_fall = (r_state == SHIFT) & r_bclk & (r_div_cnt == DW'(BCLK_DIV - 1));
  assign w_last_bit  = (r_slot == CW'(CHANNELS - 1)) & (r_slot_bit == SW'(SLOT_W - 1));
  assign w_slot_end  = w_bclk_fall & ~w_last_bit & (r_slot_bit == SW'(SLOT_W - 1));
  assign w_pop       = w_fs_commit | (w_slot_end & r_commit);
  assign w_ovf_evt   = w_push_req & w_fifo_full & ~w_pop;
  assign w_unused    = ^writedata;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push_req),
    .i_data  (writedata[SAMPLE_W-1:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_fs_commit = 1'b0;
    w_fs_starve = 1'b0;
    case (r_state)
      IDLE: if (r_en) w_state_nx = FRAME_START;
      FRAME_START: begin
        if (!r_en) begin
          w_state_nx = IDLE;
        end else begin
          w_state_nx  = SHIFT;
          w_fs_commit = w_level_ok;
          w_fs_starve = ~w_level_ok;
        end
      end
      SHIFT: if (w_bclk_fall && w_last_bit) w_state_nx = FRAME_START;
      default: w_state_nx = IDLE;
    endcase
  end

  // Serial data trails the slot counter by one BCLK, so period 0 of a frame
  // carries the previous frame's last bit and the MSB lands one BCLK after LRCK.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_lrck     <= 1'b0;
      r_dacdat   <= 1'b0;
      r_slot     <= '0;
      r_slot_bit <= '0;
      r_shift    <= '0;
      r_commit   <= 1'b0;
    end else begin
      case (r_state)
        FRAME_START: begin
          r_div_cnt <= '0;
          r_bclk    <= 1'b0;
          if (!r_en) begin
            r_lrck   <= 1'b0;
            r_dacdat <= 1'b0;
          end else begin
            r_slot     <= '0;
            r_slot_bit <= '0;
            r_commit   <= w_fs_commit;
            r_shift    <= w_fs_commit ? w_load_word : '0;
            r_lrck     <= (C_MODE == TDM);
          end
        end
        SHIFT: begin
          if (r_div_cnt == DW'(BCLK_DIV - 1)) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
          if (w_bclk_fall) begin
            r_dacdat <= r_shift[SLOT_W-1];
            if (!w_last_bit) begin
              if (C_MODE == TDM) r_lrck <= 1'b0;
              if (w_slot_end) begin
                r_slot_bit <= '0;
                r_slot     <= r_slot + CW'(1);
                r_shift    <= r_commit ? w_load_word : '0;
                if (C_MODE == I2S) r_lrck <= 1'b1;
              end else begin
                r_slot_bit <= r_slot_bit + SW'(1);
                r_shift    <= r_shift << 1;
              end
            end
          end
        end
        default: begin
          r_div_cnt <= '0;
          r_bclk    <= 1'b0;
          r_lrck    <= 1'b0;
          r_dacdat  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_status                    = '0;
    w_status[15:0]              = 16'(w_fifo_level);
    w_status[STAT_FULL_BIT]     = w_fifo_full;
    w_status[STAT_EMPTY_BIT]    = w_fifo_empty;
    w_status[STAT_UNDERRUN_BIT] = r_underrun;
    w_status[STAT_OVERFLOW_BIT] = r_overflow;
  end

  // Sticky flags: a set event in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_thresh   <= 16'(DEPTH / 2);
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (w_reg_wr && address == ADDR_CTRL) begin
        r_en     <= writedata[CTRL_EN_BIT];
        r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
      end
      if (w_reg_wr && address == ADDR_THRESH) r_thresh <= writedata[15:0];
      r_underrun <= w_fs_starve | (r_underrun &
                    ~(w_reg_wr && address == ADDR_STATUS && writedata[STAT_UNDERRUN_BIT]));
      r_overflow <= w_ovf_evt | (r_overflow &
                    ~(w_reg_wr && address == ADDR_STATUS && writedata[STAT_OVERFLOW_BIT]));
      if (chipselect && read) begin
        case (address)
          ADDR_CTRL:   r_readdata <= {30'd0, r_irq_en, r_en};
          ADDR_STATUS: r_readdata <= w_status;
          ADDR_THRESH: r_readdata <= {16'd0, r_thresh};
          default:     r_readdata <= '0;
        endcase
      end
    end
  end

  assign readdata     = r_readdata;
  assign source_ready = ~w_fifo_full;
  assign irq          = r_irq_en & ((16'(w_fifo_level) < r_thresh) | r_underrun | r_overflow);
  assign aud_bclk     = r_bclk;
  assign aud_lrck     = r_lrck;
  assign aud_dacdat   = r_dacdat;

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_stream_out
// Description : Directed bench for audio_stream_out (I2S default + TDM build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_stream_out;
  import audio_out_pkg::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset;
  logic        a_cs, a_wr, a_rd, b_cs, b_wr, b_rd;
  logic [1:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_srdy, a_irq, a_bclk, a_lrck, a_dat;
  logic        b_srdy, b_irq, b_bclk, b_lrck, b_dat;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic cap_lr [0:255];
  logic cap_d  [0:255];
  int   cap_t  [0:255];
  logic [31:0] rd;

  always @(posedge clk) cyc <= cyc + 1;

  audio_stream_out u_dut_a (
    .clk (clk), .reset (reset), .chipselect (a_cs), .write (a_wr), .read (a_rd),
    .address (a_addr), .writedata (a_wdata), .readdata (a_rdata),
    .source_ready (a_srdy), .irq (a_irq),
    .aud_bclk (a_bclk), .aud_lrck (a_lrck), .aud_dacdat (a_dat)
  );

  audio_stream_out #(
    .SAMPLE_W (16), .SLOT_W (16), .CHANNELS (4), .DEPTH (16), .BCLK_DIV (2), .MODE (1)
  ) u_dut_b (
    .clk (clk), .reset (reset), .chipselect (b_cs), .write (b_wr), .read (b_rd),
    .address (b_addr), .writedata (b_wdata), .readdata (b_rdata),
    .source_ready (b_srdy), .irq (b_irq),
    .aud_bclk (b_bclk), .aud_lrck (b_lrck), .aud_dacdat (b_dat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input bit sel, input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    if (sel) begin b_cs = 1; b_wr = 1; b_addr = addr; b_wdata = data; end
    else     begin a_cs = 1; a_wr = 1; a_addr = addr; a_wdata = data; end
    @(negedge clk);
    a_cs = 0; a_wr = 0; b_cs = 0; b_wr = 0;
  endtask

  task automatic bus_read(input bit sel, input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    if (sel) begin b_cs = 1; b_rd = 1; b_addr = addr; end
    else     begin a_cs = 1; a_rd = 1; a_addr = addr; end
    @(negedge clk);
    data = sel ? b_rdata : a_rdata;
    a_cs = 0; a_rd = 0; b_cs = 0; b_rd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  // Records LRCK/DATA/cycle at each BCLK rising edge.
  task automatic capture(input bit sel, input int n);
    logic prev, cur;
    int   got;
    int   budget;
    got    = 0;
    budget = n * 40 + 200;
    prev   = sel ? b_bclk : a_bclk;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      cur = sel ? b_bclk : a_bclk;
      if (!prev && cur) begin
        cap_lr[got] = sel ? b_lrck : a_lrck;
        cap_d[got]  = sel ? b_dat  : a_dat;
        cap_t[got]  = cyc;
        got++;
      end
      prev = cur;
    end
    if (got < n) check_eq("capture_timeout", got, n);
  endtask

  function automatic logic [31:0] pack(input bit lr, input int start);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], lr ? cap_lr[start+i] : cap_d[start+i]};
    return w;
  endfunction

  task automatic check_i2s(input string tag, input logic [31:0] w0, input logic [31:0] w1);
    check_eq({tag, "_lrck_lo"}, pack(1, 0), 32'h0000_0000);
    check_eq({tag, "_lrck_hi"}, pack(1, 32), 32'hFFFF_FFFF);
    check_eq({tag, "_slot0"}, pack(0, 1), w0);
    check_eq({tag, "_slot1"}, pack(0, 33), w1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    a_cs = 0; a_wr = 0; a_rd = 0; a_addr = '0; a_wdata = '0;
    b_cs = 0; b_wr = 0; b_rd = 0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 0;

    // Reset state
    check_eq("rst_readdata", a_rdata, 32'h0);
    check_eq("rst_irq", {31'd0, a_irq}, 32'h0);
    check_eq("rst_aud", {29'd0, a_bclk, a_lrck, a_dat}, 32'h0);
    check_eq("rst_srdy", {31'd0, a_srdy}, 32'h1);
    bus_read(0, ADDR_STATUS, rd); check_eq("rst_status", rd, 32'h0002_0000);
    bus_read(0, ADDR_THRESH, rd); check_eq("rst_thresh", rd, 32'h0000_0080);
    bus_read(0, ADDR_CTRL, rd);   check_eq("rst_ctrl", rd, 32'h0);

    // One I2S frame, then starved frame
    bus_write(0, ADDR_DATA, 32'h0000_1234);
    bus_write(0, ADDR_DATA, 32'h0000_ABCD);
    bus_read(0, ADDR_STATUS, rd); check_eq("lvl2", rd, 32'h0000_0002);
    bus_write(0, ADDR_CTRL, 32'h1);
    capture(0, 65);
    check_i2s("i2s", 32'h1234_0000, 32'hABCD_0000);
    check_eq("frame_period", cap_t[64] - cap_t[0], 32'd513);
    bus_write(0, ADDR_CTRL, 32'h0);
    repeat (600) @(negedge clk);
    check_eq("idle_aud", {29'd0, a_bclk, a_lrck, a_dat}, 32'h0);
    bus_read(0, ADDR_STATUS, rd); check_eq("lvl0_underrun", rd, 32'h0102_0000);
    bus_write(0, ADDR_STATUS, 32'h0100_0000);
    bus_read(0, ADDR_STATUS, rd); check_eq("underrun_clr", rd, 32'h0002_0000);

    // Single queued sample: zero frame, no pop
    bus_write(0, ADDR_DATA, 32'h0000_5555);
    bus_write(0, ADDR_CTRL, 32'h1);
    capture(0, 65);
    check_eq("zero_slot0", pack(0, 1), 32'h0);
    check_eq("zero_slot1", pack(0, 33), 32'h0);
    bus_write(0, ADDR_CTRL, 32'h0);
    repeat (600) @(negedge clk);
    bus_read(0, ADDR_STATUS, rd); check_eq("starve_status", rd, 32'h0100_0001);
    bus_write(0, ADDR_STATUS, 32'h0100_0000);
    bus_read(0, ADDR_STATUS, rd); check_eq("starve_clr", rd, 32'h0000_0001);

    // Reset mid-SHIFT, then replay
    bus_write(0, ADDR_CTRL, 32'h1);
    repeat (100) @(negedge clk);
    bus_read(0, ADDR_STATUS, rd); check_eq("mid_status", rd, 32'h0100_0001);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check_eq("midrst_aud", {29'd0, a_bclk, a_lrck, a_dat}, 32'h0);
    check_eq("midrst_readdata", a_rdata, 32'h0);
    bus_read(0, ADDR_STATUS, rd); check_eq("midrst_status", rd, 32'h0002_0000);
    bus_write(0, ADDR_DATA, 32'h0000_BEEF);
    bus_write(0, ADDR_DATA, 32'h0000_0F0F);
    bus_write(0, ADDR_CTRL, 32'h1);
    capture(0, 65);
    check_i2s("replay", 32'hBEEF_0000, 32'h0F0F_0000);
    bus_write(0, ADDR_CTRL, 32'h0);
    do_reset();

    // Overflow
    for (int i = 0; i < 256; i++) begin
      bus_write(0, ADDR_DATA, i);
      if (i == 254) check_eq("srdy_255", {31'd0, a_srdy}, 32'h1);
    end
    check_eq("srdy_256", {31'd0, a_srdy}, 32'h0);
    bus_write(0, ADDR_DATA, 32'h0000_7777);
    bus_read(0, ADDR_STATUS, rd); check_eq("ovf_status", rd, 32'h0201_0100);
    bus_write(0, ADDR_STATUS, 32'h0200_0000);
    bus_read(0, ADDR_STATUS, rd); check_eq("ovf_clr", rd, 32'h0001_0100);
    do_reset();

    // Threshold interrupt
    for (int i = 0; i < 5; i++) bus_write(0, ADDR_DATA, 32'h100 + i);
    bus_write(0, ADDR_THRESH, 32'h4);
    bus_write(0, ADDR_CTRL, 32'h2);
    bus_read(0, ADDR_THRESH, rd); check_eq("thresh_rb", rd, 32'h4);
    check_eq("irq_lvl5", {31'd0, a_irq}, 32'h0);
    bus_write(0, ADDR_CTRL, 32'h3);
    repeat (300) @(negedge clk);
    bus_write(0, ADDR_CTRL, 32'h2);
    repeat (600) @(negedge clk);
    bus_read(0, ADDR_STATUS, rd); check_eq("irq_lvl3_status", rd, 32'h0000_0003);
    check_eq("irq_lvl3", {31'd0, a_irq}, 32'h1);
    bus_write(0, ADDR_DATA, 32'h0000_0001);
    bus_write(0, ADDR_DATA, 32'h0000_0002);
    check_eq("irq_lvl5_again", {31'd0, a_irq}, 32'h0);

    // TDM, 4 channels x 16-bit slots
    for (int i = 1; i <= 8; i++) bus_write(1, ADDR_DATA, {16'd0, {4{i[3:0]}}});
    bus_write(1, ADDR_CTRL, 32'h1);
    capture(1, 129);
    check_eq("tdm_lrck0", pack(1, 0), 32'h8000_0000);
    check_eq("tdm_lrck1", pack(1, 32), 32'h0);
    check_eq("tdm_lrck2", pack(1, 64), 32'h8000_0000);
    check_eq("tdm_lrck3", pack(1, 96), 32'h0);
    check_eq("tdm_s01", pack(0, 1), 32'h1111_2222);
    check_eq("tdm_s23", pack(0, 33), 32'h3333_4444);
    check_eq("tdm_s45", pack(0, 65), 32'h5555_6666);
    check_eq("tdm_s67", pack(0, 97), 32'h7777_8888);
    check_eq("tdm_period", cap_t[64] - cap_t[0], 32'd257);
    bus_write(1, ADDR_CTRL, 32'h0);
    repeat (300) @(negedge clk);
    bus_read(1, ADDR_STATUS, rd); check_eq("tdm_level", rd & 32'h0003_FFFF, 32'h0002_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
